// File: rtl/seq_divider_if.sv
// Request/result bundle for seq_divider: operands and start from the requester,
// status and results back from the divider.
interface seq_divider_if #(
    parameter int WIDTH = 16
);
    // start is a request that is taken only while the divider is idle; there is
    // no ready signal, so a requester waits for busy low before pulsing start.
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_by_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_by_zero
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned divider by repeated subtraction: one subtraction per cycle,
// one-cycle done pulse, divide-by-zero flag held until the next accepted start.
module seq_divider #(
    parameter int WIDTH = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    seq_divider_if.slave      io_bus,
    output logic [1:0]        o_state
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_COMP = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;
    logic             r_dbz;
    logic             r_busy;
    logic             r_done;

    logic             w_ge;
    logic [WIDTH-1:0] w_diff;

    assign w_ge   = (r_rem >= r_div);
    assign w_diff = r_rem - r_div;

    // busy/done are registered alongside the state so they track it exactly.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_quo   <= '0;
            r_div   <= '0;
            r_dbz   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.start) begin
                        r_rem   <= io_bus.dividend;
                        r_div   <= io_bus.divisor;
                        r_quo   <= '0;
                        r_dbz   <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_COMP;
                    end
                end
                S_COMP: begin
                    if (r_div == '0) begin
                        r_dbz   <= 1'b1;
                        r_quo   <= '1;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else if (w_ge) begin
                        r_rem <= w_diff;
                        r_quo <= r_quo + ONE;
                    end else begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.busy        = r_busy;
    assign io_bus.done        = r_done;
    assign io_bus.quotient    = r_quo;
    assign io_bus.remainder   = r_rem;
    assign io_bus.div_by_zero = r_dbz;
    assign o_state            = r_state;
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a 16-bit and an 8-bit instance, directed cases plus
// random operands checked against plain integer division.
module tb_seq_divider;
    localparam int BUDGET = 1000;

    logic clk;
    logic rst_n;
    logic [1:0] state16;
    logic [1:0] state8;

    seq_divider_if #(.WIDTH(16)) bus16 ();
    seq_divider_if #(.WIDTH(8))  bus8  ();

    seq_divider #(.WIDTH(16)) u_dut16 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus16.slave),
        .o_state (state16)
    );

    seq_divider #(.WIDTH(8)) u_dut8 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .io_bus  (bus8.slave),
        .o_state (state8)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_err;
    logic [31:0] exp_q[$];
    bit sel8;

    logic        w_busy;
    logic        w_done;
    logic [15:0] w_quo;
    logic [15:0] w_rem;
    logic        w_dbz;

    assign w_busy = sel8 ? bus8.busy        : bus16.busy;
    assign w_done = sel8 ? bus8.done        : bus16.done;
    assign w_quo  = sel8 ? {8'h00, bus8.quotient}  : bus16.quotient;
    assign w_rem  = sel8 ? {8'h00, bus8.remainder} : bus16.remainder;
    assign w_dbz  = sel8 ? bus8.div_by_zero : bus16.div_by_zero;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic drive(input bit use8, input bit st, input logic [15:0] a, input logic [15:0] b);
        if (use8) begin
            bus8.start    = st;
            bus8.dividend = a[7:0];
            bus8.divisor  = b[7:0];
        end else begin
            bus16.start    = st;
            bus16.dividend = a;
            bus16.divisor  = b;
        end
    endtask

    // Reference: plain integer division, latency derived from the quotient.
    task automatic model(input bit use8, input logic [15:0] a_in, input logic [15:0] b_in);
        int a, b, all1;
        a    = use8 ? int'(a_in[7:0]) : int'(a_in);
        b    = use8 ? int'(b_in[7:0]) : int'(b_in);
        all1 = use8 ? 255 : 65535;
        if (b == 0) begin
            exp_q.push_back(all1);
            exp_q.push_back(a);
            exp_q.push_back(1);
            exp_q.push_back(1);
        end else begin
            exp_q.push_back(a / b);
            exp_q.push_back(a % b);
            exp_q.push_back(0);
            exp_q.push_back(a / b + 1);
        end
    endtask

    // One division; optionally pulses an interfering start after edge intr_at.
    task automatic run_div(input bit use8, input logic [15:0] a, input logic [15:0] b,
                           input int intr_at, input logic [15:0] ia, input logic [15:0] ib);
        int lat;
        bit seen;
        logic [31:0] eq, er, ed, el;
        sel8 = use8;
        model(use8, a, b);
        eq = exp_q.pop_front();
        er = exp_q.pop_front();
        ed = exp_q.pop_front();
        el = exp_q.pop_front();
        @(negedge clk);
        drive(use8, 1'b1, a, b);
        @(posedge clk);
        #1;
        drive(use8, 1'b0, a, b);
        check_val("busy_after_start", {31'd0, w_busy}, 32'd1);
        lat  = 0;
        seen = 1'b0;
        while (!seen && lat < BUDGET) begin
            @(posedge clk);
            #1;
            lat++;
            if (w_done) seen = 1'b1;
            else if (lat == intr_at) drive(use8, 1'b1, ia, ib);
            else drive(use8, 1'b0, a, b);
        end
        drive(use8, 1'b0, a, b);
        check_val("done_seen", {31'd0, seen}, 32'd1);
        check_val("latency", lat, el);
        check_val("busy_in_done", {31'd0, w_busy}, 32'd1);
        check_val("quotient", {16'd0, w_quo}, eq);
        check_val("remainder", {16'd0, w_rem}, er);
        check_val("div_by_zero", {31'd0, w_dbz}, ed);
        @(posedge clk);
        #1;
        check_val("done_pulse_end", {31'd0, w_done}, 32'd0);
        check_val("busy_end", {31'd0, w_busy}, 32'd0);
        check_val("quotient_hold", {16'd0, w_quo}, eq);
        check_val("remainder_hold", {16'd0, w_rem}, er);
        check_val("dbz_hold", {31'd0, w_dbz}, ed);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        n_vec = 0;
        n_err = 0;
        sel8  = 1'b0;
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 16'd0, 16'd0);
        drive(1'b1, 1'b0, 16'd0, 16'd0);
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_busy", {31'd0, w_busy}, 32'd0);
        check_val("rst_done", {31'd0, w_done}, 32'd0);
        check_val("rst_quotient", {16'd0, w_quo}, 32'd0);
        check_val("rst_remainder", {16'd0, w_rem}, 32'd0);
        check_val("rst_dbz", {31'd0, w_dbz}, 32'd0);
        check_val("rst_state", {30'd0, state16}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_div(1'b0, 16'd7,   16'd2, -1, 16'd0, 16'd0);
        run_div(1'b0, 16'd5,   16'd9, -1, 16'd0, 16'd0);
        run_div(1'b0, 16'd12,  16'd0, -1, 16'd0, 16'd0);
        run_div(1'b0, 16'd20,  16'd4, -1, 16'd0, 16'd0);
        run_div(1'b1, 16'd255, 16'd1, -1, 16'd0, 16'd0);
        run_div(1'b0, 16'd100, 16'd7, 3, 16'd9, 16'd3);

        // Reset in the middle of a division.
        sel8 = 1'b0;
        @(negedge clk);
        drive(1'b0, 1'b1, 16'd1000, 16'd3);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'd1000, 16'd3);
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_val("midrst_busy", {31'd0, w_busy}, 32'd0);
        check_val("midrst_done", {31'd0, w_done}, 32'd0);
        check_val("midrst_quotient", {16'd0, w_quo}, 32'd0);
        check_val("midrst_remainder", {16'd0, w_rem}, 32'd0);
        check_val("midrst_dbz", {31'd0, w_dbz}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_div(1'b0, 16'd10, 16'd5, -1, 16'd0, 16'd0);

        // Random operands with the quotient kept small to bound run time.
        for (int i = 0; i < 30; i++) begin
            int a, b, hi;
            bit use8;
            use8 = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) b = 0;
            else b = $urandom_range(1, use8 ? 255 : 65535);
            hi = (b == 0) ? 65535 : b * 150 + b - 1;
            if (hi > (use8 ? 255 : 65535)) hi = use8 ? 255 : 65535;
            a = $urandom_range(0, hi);
            run_div(use8, a[15:0], b[15:0], -1, 16'd0, 16'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
